// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with 64-bit lines,
// sitting between the fetch stage and the tagged main-memory bus.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   Imem2proc_response    nonzero = BUS_LOAD accepted, value is its tag
//   Imem2proc_data/tag    reply data and its tag (tag 0 = no reply)
//   proc2Icache_addr      fetch address
//   read_valid            fetch requests a read this cycle
//   Icache_valid_out      Icache_data_out holds the line for the fetch address
//   Icache_data_out       line data, 0 when Icache_valid_out = 0
//   proc2Imem_command     0 = BUS_NONE, 1 = BUS_LOAD (BUS_STORE = 2 is never driven)
//   proc2Imem_addr        line-aligned fetch address
//   hit_count, miss_count saturating performance counters, present only
//                         when ICACHE_PERF_CNT_EN is defined
//
// Handshake: in IDLE a miss drives BUS_LOAD every cycle until the memory
// answers with a nonzero response; that response is the tag the matching
// reply will carry on Imem2proc_tag. One miss is outstanding at a time.
//
// The FSM state is visible as the internal signal `state` (type state_t).
module icache #(
  parameter int XLEN      = 32,
  parameter int NUM_LINES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      Imem2proc_response,
  input  logic [63:0]     Imem2proc_data,
  input  logic [3:0]      Imem2proc_tag,
  input  logic [XLEN-1:0] proc2Icache_addr,
  input  logic            read_valid,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count,
`endif
  output logic            Icache_valid_out,
  output logic [1:0]      proc2Imem_command,
  output logic [XLEN-1:0] proc2Imem_addr,
  output logic [63:0]     Icache_data_out
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = XLEN - 3 - IDX_W;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state, state_next;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [63:0]          data_q [NUM_LINES];

  logic [3:0]       mem_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             hit, issue, accept, fill, abandon;

  assign fetch_idx = proc2Icache_addr[3 +: IDX_W];
  assign fetch_tag = proc2Icache_addr[XLEN-1 -: TAG_W];

  assign hit    = read_valid & valid_q[fetch_idx] & (tag_q[fetch_idx] == fetch_tag);
  assign issue  = (state == S_IDLE) & read_valid & ~hit & ~reset;
  assign accept = issue & (Imem2proc_response != 4'd0);
  // mem_tag == 0 means "nothing expected", so a tag-0 idle bus never fills.
  assign fill   = (state == S_WAIT) & (mem_tag != 4'd0) & (Imem2proc_tag == mem_tag);
  // Fetch moved to a different line while the miss was in flight.
  assign abandon = (state == S_WAIT) & read_valid &
                   ((fetch_idx != miss_idx) | (fetch_tag != miss_tag));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept)          state_next = S_WAIT;
      S_WAIT: if (fill | abandon)  state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
    Icache_valid_out  = hit & ~reset;
    Icache_data_out   = Icache_valid_out ? data_q[fetch_idx] : 64'd0;
  end

  // Masking rather than slicing keeps the offset bits out of the address.
  assign proc2Imem_addr = proc2Icache_addr & ~XLEN'(7);

  // ---------------- miss bookkeeping ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_tag  <= 4'd0;
      miss_idx <= '0;
      miss_tag <= '0;
    end else if (accept) begin
      mem_tag  <= Imem2proc_response;
      miss_idx <= fetch_idx;
      miss_tag <= fetch_tag;
    end else if (fill | abandon) begin
      // Clearing mem_tag makes a late reply for an abandoned miss harmless.
      mem_tag <= 4'd0;
    end
  end

  // ---------------- line storage ----------------
  always_ff @(posedge clk) begin
    if (reset)     valid_q <= '0;
    else if (fill) valid_q[miss_idx] <= 1'b1;
  end

  // Tag/data need no reset; they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (fill && !reset) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= Imem2proc_data;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit && hit_count != 32'hFFFF_FFFF)     hit_count  <= hit_count + 32'd1;
      if (accept && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: hand-computed vectors covering reset,
// cold miss and fill, rejected requests, index conflicts, abandoned misses
// and offset-insensitive hits.
module tb_icache;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  resp;
  logic [63:0] mdata;
  logic [3:0]  mtag;
  logic [31:0] addr;
  logic        rv;
  logic        vo;
  logic [1:0]  cmd;
  logic [31:0] paddr;
  logic [63:0] dout;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  icache dut (
    .clk                (clk),
    .reset              (reset),
    .Imem2proc_response (resp),
    .Imem2proc_data     (mdata),
    .Imem2proc_tag      (mtag),
    .proc2Icache_addr   (addr),
    .read_valid         (rv),
`ifdef ICACHE_PERF_CNT_EN
    .hit_count          (hit_count),
    .miss_count         (miss_count),
`endif
    .Icache_valid_out   (vo),
    .proc2Imem_command  (cmd),
    .proc2Imem_addr     (paddr),
    .Icache_data_out    (dout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 2 units later, well clear of either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    rv = 1'b0; addr = 32'd0; resp = 4'd0; mtag = 4'd0; mdata = 64'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Miss on a, accepted with tag t, reply with d on the following cycle.
  task automatic fill_line(input logic [31:0] a, input logic [3:0] t, input logic [63:0] d);
    rv = 1'b1; addr = a; resp = t;
    settle();
    check("fill_cmd", 64'(cmd), 64'd1);
    check("fill_vo",  64'(vo),  64'd0);
    tick();
    resp = 4'd0; mtag = t; mdata = d;
    tick();
    mtag = 4'd0; mdata = 64'd0;
  endtask

  initial begin
    // ---------- reset ----------
    idle_inputs();
    reset = 1'b1;
    rv = 1'b1; addr = 32'h0;
    tick();
    settle();
    check("rst_cmd",  64'(cmd),  64'd0);
    check("rst_vo",   64'(vo),   64'd0);
    check("rst_data", dout,      64'd0);
    tick();
    reset = 1'b0;
    settle();
    check("post_rst_cmd",  64'(cmd),   64'd1);
    check("post_rst_addr", 64'(paddr), 64'h0);
    tick();

    // ---------- cold miss @0x104 ----------
    do_reset();
    rv = 1'b1; addr = 32'h104; resp = 4'd3;
    settle();
    check("cold_cmd",  64'(cmd),   64'd1);
    check("cold_addr", 64'(paddr), 64'h100);
    check("cold_vo",   64'(vo),    64'd0);
    tick();
    resp = 4'd0;
    settle();
    check("cold_wait_cmd", 64'(cmd), 64'd0);
    tick();
    mtag = 4'd3; mdata = 64'hDEAD_BEEF_CAFE_F00D;
    settle();
    check("cold_no_bypass", 64'(vo), 64'd0);
    tick();
    mtag = 4'd0; mdata = 64'd0;
    settle();
    check("cold_hit_vo",   64'(vo),  64'd1);
    check("cold_hit_data", dout,     64'hDEAD_BEEF_CAFE_F00D);
    check("cold_hit_cmd",  64'(cmd), 64'd0);
    tick();
    rv = 1'b0;
    settle();
    check("rv0_vo",   64'(vo),  64'd0);
    check("rv0_data", dout,     64'd0);
    check("rv0_cmd",  64'(cmd), 64'd0);
    tick();

    // ---------- rejected requests ----------
    do_reset();
    rv = 1'b1; addr = 32'h100; resp = 4'd0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rej_cmd",  64'(cmd),   64'd1);
      check("rej_addr", 64'(paddr), 64'h100);
      tick();
    end
    resp = 4'd5;
    settle();
    check("acc_cmd", 64'(cmd), 64'd1);
    tick();
    resp = 4'd0;
    settle();
    check("acc_wait_cmd", 64'(cmd), 64'd0);
    // a reply with a foreign tag must be ignored
    mtag = 4'd4; mdata = 64'h1111_2222_3333_4444;
    tick();
    mtag = 4'd0;
    settle();
    check("foreign_tag_vo", 64'(vo), 64'd0);
    mtag = 4'd5; mdata = 64'h5555_6666_7777_8888;
    tick();
    mtag = 4'd0; mdata = 64'd0;
    settle();
    check("rej_fill_vo",   64'(vo), 64'd1);
    check("rej_fill_data", dout,    64'h5555_6666_7777_8888);
    tick();

    // ---------- conflict on the same index ----------
    do_reset();
    fill_line(32'h008, 4'd1, 64'hAAAA_0000_0000_0008);
    settle();
    check("conf_a_vo",   64'(vo), 64'd1);
    check("conf_a_data", dout,    64'hAAAA_0000_0000_0008);
    tick();
    fill_line(32'h108, 4'd2, 64'hBBBB_0000_0000_0108);
    settle();
    check("conf_b_vo",   64'(vo), 64'd1);
    check("conf_b_data", dout,    64'hBBBB_0000_0000_0108);
    tick();
    addr = 32'h008;
    settle();
    check("conf_a_evicted_vo",  64'(vo),   64'd0);
    check("conf_a_evicted_cmd", 64'(cmd),  64'd1);
    check("conf_a_evicted_adr", 64'(paddr), 64'h008);
    tick();

    // ---------- abandoned miss ----------
    do_reset();
    rv = 1'b1; addr = 32'h200; resp = 4'd2;
    settle();
    check("abn_cmd", 64'(cmd), 64'd1);
    tick();
    resp = 4'd0; addr = 32'h300;
    settle();
    check("abn_switch_cmd", 64'(cmd), 64'd0);
    tick();
    settle();
    check("abn_new_miss_cmd",  64'(cmd),   64'd1);
    check("abn_new_miss_addr", 64'(paddr), 64'h300);
    rv = 1'b0; mtag = 4'd2; mdata = 64'h0BAD_0BAD_0BAD_0BAD;
    tick();
    mtag = 4'd0; mdata = 64'd0;
    rv = 1'b1; addr = 32'h200;
    settle();
    check("abn_200_vo",  64'(vo),  64'd0);
    check("abn_200_cmd", 64'(cmd), 64'd1);
    rv = 1'b1; addr = 32'h300;
    settle();
    check("abn_300_vo", 64'(vo), 64'd0);
    tick();

    // ---------- offset bits ignored ----------
    do_reset();
    fill_line(32'h040, 4'd7, 64'h0123_4567_89AB_CDEF);
    addr = 32'h044;
    settle();
    check("ofs_44_vo",   64'(vo), 64'd1);
    check("ofs_44_data", dout,    64'h0123_4567_89AB_CDEF);
    addr = 32'h047;
    settle();
    check("ofs_47_vo",  64'(vo),    64'd1);
    check("ofs_47_cmd", 64'(cmd),   64'd0);
    addr = 32'h048;
    settle();
    check("ofs_48_vo",   64'(vo),   64'd0);
    check("ofs_48_addr", 64'(paddr), 64'h048);
    tick();

    // ---------- reset clears valid lines ----------
    do_reset();
    rv = 1'b1; addr = 32'h040;
    settle();
    check("rst_clears_vo", 64'(vo), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
